// File: rtl/idli_seq_pkg.sv
// Shared types and constants for the nibble-serial execution sequencer.
package idli_seq_pkg;

    localparam int NIBBLES_PER_WORD = 4;

    typedef logic [2:0] greg_t;
    typedef logic [3:0] nibble_t;

    localparam greg_t GREG_PC = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        ALIGN = 3'd3,
        WB    = 3'd4
    } seq_state_t;

    // Decoded instruction fields held for the duration of one instruction.
    typedef struct packed {
        greg_t a;
        greg_t b;
        greg_t c;
        logic  wr;
        logic  br;
        logic  mem;
        logic  ld;
    } instr_t;

    // Non-memory write to r7: the GRF write port owns the PC this word.
    function automatic logic is_pc_write(input instr_t ins);
        return ins.wr & ~ins.mem & (ins.a == GREG_PC);
    endfunction

    // Load that writes a register needs a WB word after the memory phase.
    function automatic logic needs_wb(input instr_t ins);
        return ins.mem & ins.ld & ins.wr;
    endfunction

endpackage

// File: rtl/idli_seq_pcinc.sv
// Serial PC+1 incrementer: one nibble per cycle, carry kept between nibbles,
// +1 injected on the first nibble of the word, branch target muxed in.
module idli_seq_pcinc_m
    import idli_seq_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  logic    first,
    input  logic    br,
    input  nibble_t pc_nib,
    input  nibble_t alu_nib,
    output nibble_t nxt_nib
);

    logic       carry_r;
    logic       carry_in_s;
    logic [4:0] sum_s;

    // Nibble add with carry-in, then select branch target or increment.
    always_comb begin
        carry_in_s = 1'b0;
        sum_s      = 5'd0;
        nxt_nib    = 4'd0;
        if (first) begin
            carry_in_s = 1'b1;
        end else begin
            carry_in_s = carry_r;
        end
        sum_s = {1'b0, pc_nib} + {4'b0000, carry_in_s};
        if (br) begin
            nxt_nib = alu_nib;
        end else begin
            nxt_nib = sum_s[3:0];
        end
    end

    // Carry register; the carry out of the top nibble is overwritten by the
    // next word's injected +1, so the PC wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_r <= 1'b0;
        end else if (en) begin
            carry_r <= sum_s[4];
        end else begin
            carry_r <= 1'b0;
        end
    end

endmodule

// File: rtl/idli_seq_m.sv
// Execution sequencer for the nibble-serial GRF: free-running nibble phase,
// word-aligned instruction accept, GRF select/write control, serial PC
// update and load/store memory sequencing.
module idli_seq_m
    import idli_seq_pkg::*;
#(
    parameter int NIB_CNT_W = 2
)
(
    input  logic                 i_seq_gck,
    input  logic                 i_seq_rst_n,
    input  logic                 i_seq_instr_vld,
    output logic                 o_seq_instr_rdy,
    input  logic [2:0]           i_seq_instr_a,
    input  logic [2:0]           i_seq_instr_b,
    input  logic [2:0]           i_seq_instr_c,
    input  logic                 i_seq_instr_wr,
    input  logic                 i_seq_instr_br,
    input  logic                 i_seq_instr_mem,
    input  logic                 i_seq_instr_ld,
    input  logic [3:0]           i_seq_alu_data,
    output logic [2:0]           o_seq_grf_b,
    output logic [2:0]           o_seq_grf_c,
    output logic [2:0]           o_seq_grf_a,
    output logic                 o_seq_grf_a_vld,
    output logic [3:0]           o_seq_grf_a_data,
    input  logic [3:0]           i_seq_grf_pc_data,
    output logic                 o_seq_grf_pc_vld,
    output logic [3:0]           o_seq_grf_pc_data,
    output logic                 o_seq_mem_req,
    input  logic                 i_seq_mem_ack,
    input  logic [3:0]           i_seq_mem_data,
    output logic [NIB_CNT_W-1:0] o_seq_phase
);

    localparam logic [NIB_CNT_W-1:0] PHASE_FIRST = {NIB_CNT_W{1'b0}};
    localparam logic [NIB_CNT_W-1:0] PHASE_LAST  = NIB_CNT_W'(NIBBLES_PER_WORD - 1);
    localparam logic [NIB_CNT_W-1:0] PHASE_ONE   = {{(NIB_CNT_W-1){1'b0}}, 1'b1};

    seq_state_t           state_r;
    seq_state_t           state_nxt_s;
    logic [NIB_CNT_W-1:0] phase_r;
    instr_t               instr_r;
    instr_t               instr_in_s;

    logic    phase_last_s;
    logic    ret_s;
    logic    capture_s;
    logic    rdy_s;
    logic    a_vld_s;
    nibble_t a_data_s;
    logic    pc_vld_s;
    logic    req_s;
    logic    pcinc_en_s;
    nibble_t pc_nxt_s;

    assign instr_in_s = '{a:   i_seq_instr_a,
                          b:   i_seq_instr_b,
                          c:   i_seq_instr_c,
                          wr:  i_seq_instr_wr,
                          br:  i_seq_instr_br,
                          mem: i_seq_instr_mem,
                          ld:  i_seq_instr_ld};

    assign phase_last_s = (phase_r == PHASE_LAST);

    idli_seq_pcinc_m u_pcinc (
        .clk     (i_seq_gck),
        .rst_n   (i_seq_rst_n),
        .en      (pcinc_en_s),
        .first   (phase_r == PHASE_FIRST),
        .br      (instr_r.br),
        .pc_nib  (i_seq_grf_pc_data),
        .alu_nib (i_seq_alu_data),
        .nxt_nib (pc_nxt_s)
    );

    // Next-state and output decode; ret_s marks a word-end cycle where the
    // sequencer is free to accept the next instruction or fall back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        ret_s       = 1'b0;
        capture_s   = 1'b0;
        rdy_s       = 1'b0;
        a_vld_s     = 1'b0;
        a_data_s    = 4'd0;
        pc_vld_s    = 1'b0;
        req_s       = 1'b0;
        pcinc_en_s  = 1'b0;

        case (state_r)
            IDLE: begin
                ret_s = phase_last_s;
            end
            EXEC: begin
                pcinc_en_s = 1'b1;
                a_vld_s    = instr_r.wr & ~instr_r.mem;
                pc_vld_s   = ~is_pc_write(instr_r);
                if (a_vld_s) begin
                    a_data_s = i_seq_alu_data;
                end else begin
                    a_data_s = 4'd0;
                end
                if (phase_last_s && instr_r.mem) begin
                    state_nxt_s = MEM;
                end else begin
                    ret_s = phase_last_s;
                end
            end
            MEM: begin
                req_s = 1'b1;
                if (i_seq_mem_ack) begin
                    if (!phase_last_s) begin
                        state_nxt_s = ALIGN;
                    end else if (needs_wb(instr_r)) begin
                        state_nxt_s = WB;
                    end else begin
                        ret_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = MEM;
                end
            end
            ALIGN: begin
                if (phase_last_s && needs_wb(instr_r)) begin
                    state_nxt_s = WB;
                end else begin
                    ret_s = phase_last_s;
                end
            end
            WB: begin
                a_vld_s  = 1'b1;
                a_data_s = i_seq_mem_data;
                ret_s    = phase_last_s;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        if (ret_s) begin
            rdy_s = 1'b1;
            if (i_seq_instr_vld) begin
                capture_s   = 1'b1;
                state_nxt_s = EXEC;
            end else begin
                state_nxt_s = IDLE;
            end
        end else begin
            capture_s = 1'b0;
        end
    end

    // Phase counter, state register and captured instruction fields.
    always_ff @(posedge i_seq_gck or negedge i_seq_rst_n) begin
        if (!i_seq_rst_n) begin
            phase_r <= PHASE_FIRST;
            state_r <= IDLE;
            instr_r <= '0;
        end else begin
            phase_r <= phase_r + PHASE_ONE;
            state_r <= state_nxt_s;
            if (capture_s) begin
                instr_r <= instr_in_s;
            end else begin
                instr_r <= instr_r;
            end
        end
    end

    assign o_seq_instr_rdy   = rdy_s;
    assign o_seq_grf_b       = instr_r.b;
    assign o_seq_grf_c       = instr_r.c;
    assign o_seq_grf_a       = instr_r.a;
    assign o_seq_grf_a_vld   = a_vld_s;
    assign o_seq_grf_a_data  = a_data_s;
    assign o_seq_grf_pc_vld  = pc_vld_s;
    assign o_seq_grf_pc_data = pc_vld_s ? pc_nxt_s : 4'd0;
    assign o_seq_mem_req     = req_s;
    assign o_seq_phase       = phase_r;

endmodule

// File: doc/idli_seq_m.md
Name: idli_seq_m

Overview:
- Execution sequencer for the nibble-serial general register file (GRF).
- Keeps the free-running nibble phase that matches the GRF's 4-bit-per-cycle rotation.
- Accepts decoded instructions only on word boundaries and drives the GRF B/C read selects, the A write select and enable, and the PC port.
- Generates the serial PC+1 and sequences the memory request/writeback for loads and stores. Sits between decode, ALU, memory interface and GRF.

Parameters:
- NIB_CNT_W, 2, width of nibble phase counter. A word is 2**NIB_CNT_W = 4 nibbles. Fixed; other values unsupported.

Ports:
- i_seq_gck  in  1  core clock
- i_seq_rst_n  in  1  reset; asynchronous assert, active-low
- i_seq_instr_vld  in  1  decoded instruction valid
- o_seq_instr_rdy  out  1  instruction accepted when vld&rdy
- i_seq_instr_a  in  3  destination greg
- i_seq_instr_b  in  3  source greg B
- i_seq_instr_c  in  3  source greg C
- i_seq_instr_wr  in  1  instruction writes A
- i_seq_instr_br  in  1  branch taken (resolved by decode)
- i_seq_instr_mem  in  1  memory op; EXEC computes address
- i_seq_instr_ld  in  1  memory op is load (ignored unless mem)
- i_seq_alu_data  in  4  ALU result nibble, current phase
- o_seq_grf_b  out  3  GRF read select B
- o_seq_grf_c  out  3  GRF read select C
- o_seq_grf_a  out  3  GRF write select
- o_seq_grf_a_vld  out  1  GRF write enable
- o_seq_grf_a_data  out  4  GRF write nibble
- i_seq_grf_pc_data  in  4  current PC nibble from GRF
- o_seq_grf_pc_vld  out  1  PC write enable
- o_seq_grf_pc_data  out  4  next-PC nibble
- o_seq_mem_req  out  1  memory request, held until ack
- i_seq_mem_ack  in  1  memory acknowledge
- i_seq_mem_data  in  4  load data nibble, streamed in WB
- o_seq_phase  out  2  current nibble phase (0 = bits 3:0)

Behaviour:
- Reset (async, active-low) forces:
  - phase=0, state=IDLE, carry=0.
  - All outputs 0; captured instruction fields 0.
  - Any in-flight memory request is dropped and no GRF write occurs.
- phase increments every cycle and wraps 3->0; it is never stalled.
- States: IDLE, EXEC, MEM, ALIGN, WB.
- IDLE:
  - o_seq_instr_rdy = (phase==3).
  - On vld&rdy, capture a/b/c/wr/br/mem/ld and go to EXEC. EXEC always starts at phase 0.
- EXEC (4 cycles, phase 0..3):
  - grf_b/c = captured b/c.
  - grf_a_vld = wr & !mem; grf_a_data = i_seq_alu_data.
  - pc_vld=1 every cycle.
    - If br: pc_data = i_seq_alu_data.
    - Else: pc_data = pc_nibble + carry_in, where carry_in=1 at phase 0, otherwise the registered carry-out of the previous nibble. Carry out of phase 3 is discarded (PC wraps 0xFFFF->0x0000).
  - If wr & !mem & a==7: pc_vld=0, so the GRF write port owns PC.
  - At phase 3:
    - If mem: go to MEM.
    - Else rdy = 1. On vld, capture and re-enter EXEC back-to-back; otherwise go to IDLE.
- MEM:
  - o_seq_mem_req=1; grf_b/c hold captured b/c so address/store data remain readable; no GRF writes.
  - On i_seq_mem_ack at any phase: drop req next cycle.
    - If ld & wr: ack at phase 3 -> WB; otherwise -> ALIGN.
    - Store or !wr: ack at phase 3 -> IDLE (rdy asserted in that cycle, same back-to-back rule as EXEC); otherwise -> ALIGN.
- ALIGN:
  - Wait, no outputs active, until phase==3.
  - At phase 3: -> WB for ld & wr; otherwise -> IDLE with rdy rules applied.
- WB (4 cycles, phase 0..3):
  - grf_a_vld=1, grf_a_data=i_seq_mem_data, pc_vld=0.
  - At phase 3, same accept/return rule as EXEC.
- GRF write is never enabled outside EXEC/WB.
- rdy is never asserted outside phase 3.
- Selects hold their last captured values in IDLE; data is don't-care with vld=0.

Decomposition:
- Shared package:
  - greg_t (3-bit register index), GREG_PC=7.
  - nibble_t (4-bit).
  - seq_state_t enum {IDLE, EXEC, MEM, ALIGN, WB}.
  - NIBBLES_PER_WORD=4.
- One sub-module, idli_seq_pcinc_m: the serial incrementer (nibble + carry-in, registered carry, phase-0 carry injection, branch mux).

Test Plan:
- Reset mid-EXEC: assert rst_n=0 at phase 2 -> same cycle a_vld=0, pc_vld=0, rdy=0. After release, phase counts 0,1,2,3 and rdy first rises at phase 3.
- ALU op, a=3 b=1 c=2 wr=1, PC=0x00FF, vld held from phase 0:
  - Accepted only at phase 3; next 4 cycles a_vld=1 with a=3.
  - pc_data nibbles 0,0,1,0 (PC=0x0100).
  - vld held at that phase 3 -> immediate second EXEC.
- Branch br=1, alu nibbles A,B,C,D -> pc_data A,B,C,D, pc_vld=1 for 4 cycles. PC 0xFFFF non-branch -> 0x0000.
- Write to PC, a=7 wr=1 -> pc_vld=0 all 4 EXEC cycles, a_vld=1, a=7.
- Load a=5 with ack at phase 1 after 6 req cycles -> req drops, ALIGN to phase 3, WB writes i_seq_mem_data nibbles into r5 over phases 0..3, pc_vld=0.
- Store with ack at phase 3 -> IDLE with rdy=1 that cycle; no a_vld pulse at any point.
